// File: rtl/mult_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mult_pkg
// Description : Shared state encoding and default operand width for the
//               serial multiply sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package mult_pkg;

   localparam int DEFAULT_WIDTH = 8;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_RUN  = 2'd2,
      S_DONE = 2'd3
   } state_t;

endpackage
`default_nettype wire

// File: rtl/mult_step_counter.sv
`default_nettype none
// ============================================================================
// Module      : mult_step_counter
// Description : Synchronous clear/enable up-counter that saturates at
//               TERMINAL-1 and flags that value.
// Revision    : 1.0 - initial release
// ============================================================================
module mult_step_counter #(
   parameter int TERMINAL = 16,
   parameter int CNT_W    = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_clr,
   input  logic             i_en,
   output logic [CNT_W-1:0] o_cnt,
   output logic             o_tc
);

   logic [CNT_W-1:0] r_cnt;
   logic             w_tc;

   assign w_tc = (r_cnt == CNT_W'(TERMINAL - 1));

   // Holding at the terminal value keeps the count in range without wrapping
   always_ff @(posedge clk) begin
      if (rst || i_clr) begin
         r_cnt <= '0;
      end else if (i_en && !w_tc) begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   assign o_cnt = r_cnt;
   assign o_tc  = w_tc;

endmodule
`default_nettype wire

// File: rtl/mult_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : mult_sequencer
// Description : Load/run/done control FSM for the serial shift-add multiply
//               datapath with a start/busy/done handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module mult_sequencer
   import mult_pkg::*;
#(
   parameter int WIDTH      = DEFAULT_WIDTH,
   parameter int RUN_CYCLES = 2 * WIDTH,
   parameter int CNT_W      = $clog2(RUN_CYCLES + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             start,
   output logic             busy,
   output logic             done,
   output logic             done_pulse,
   output logic             ld_x,
   output logic             ld_y,
   output logic             shift_y,
   output logic             spm_clr,
   output logic             prod_clr,
   output logic             prod_shift,
   output logic [CNT_W-1:0] run_cnt
);

   state_t           r_state;
   state_t           w_next_state;
   logic             r_start_q;
   logic             r_was_done;
   logic             w_trig;
   logic             w_tc;
   logic [CNT_W-1:0] w_cnt;

   // start_q follows start even through reset so a level held across reset
   // release is not mistaken for a fresh request
   always_ff @(posedge clk) begin
      r_start_q <= start;
   end

   assign w_trig = start & ~r_start_q;

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         r_state    <= S_IDLE;
         r_was_done <= 1'b0;
      end else begin
         r_state    <= w_next_state;
         r_was_done <= (r_state == S_DONE);
      end
   end

   mult_step_counter #(
      .TERMINAL (RUN_CYCLES),
      .CNT_W    (CNT_W)
   ) u_step_counter (
      .clk   (clk),
      .rst   (rst),
      .i_clr (clr || (r_state == S_LOAD)),
      .i_en  (r_state == S_RUN),
      .o_cnt (w_cnt),
      .o_tc  (w_tc)
   );

   always_comb begin
      w_next_state = r_state;
      busy         = 1'b0;
      done         = 1'b0;
      done_pulse   = 1'b0;
      ld_x         = 1'b0;
      ld_y         = 1'b0;
      shift_y      = 1'b0;
      spm_clr      = 1'b0;
      prod_clr     = 1'b0;
      prod_shift   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_trig) w_next_state = S_LOAD;
         end
         S_LOAD: begin
            busy         = 1'b1;
            ld_x         = 1'b1;
            ld_y         = 1'b1;
            spm_clr      = 1'b1;
            prod_clr     = 1'b1;
            w_next_state = S_RUN;
         end
         S_RUN: begin
            busy       = 1'b1;
            shift_y    = 1'b1;
            prod_shift = 1'b1;
            if (w_tc) w_next_state = S_DONE;
         end
         S_DONE: begin
            done       = 1'b1;
            done_pulse = ~r_was_done;
            if (w_trig) w_next_state = S_LOAD;
         end
         default: w_next_state = S_IDLE;
      endcase
   end

   assign run_cnt = w_cnt;

endmodule
`default_nettype wire

// File: tb/tb_mult_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_mult_sequencer
// Description : Scoreboard bench for mult_sequencer driving a behavioural
//               serial multiply datapath.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mult_sequencer;

   localparam int CNT_W = 5;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             clr = 1'b0;
   logic             start = 1'b0;
   logic             busy, done, done_pulse, ld_x, ld_y, shift_y;
   logic             spm_clr, prod_clr, prod_shift;
   logic [CNT_W-1:0] run_cnt;

   logic [7:0]        x_in = 8'd0;
   logic [7:0]        y_in = 8'd0;
   logic signed [7:0] x_r, y_r;
   logic signed [9:0] acc, s;
   logic [15:0]       prod;

   int cyc = 0;
   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      logic [15:0] prod;
      int          cyc;
   } exp_t;
   exp_t q[$];

   localparam logic [8:0] V_IDLE  = 9'b0_0_0_0_0_0_0_0_0;
   localparam logic [8:0] V_LOAD  = 9'b1_0_0_1_1_0_1_1_0;
   localparam logic [8:0] V_RUN   = 9'b1_0_0_0_0_1_0_0_1;
   localparam logic [8:0] V_DONE1 = 9'b0_1_1_0_0_0_0_0_0;
   localparam logic [8:0] V_DONE  = 9'b0_1_0_0_0_0_0_0_0;

   logic [8:0] ctrl;
   assign ctrl = {busy, done, done_pulse, ld_x, ld_y, shift_y, spm_clr, prod_clr, prod_shift};

   mult_sequencer #(.WIDTH(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .clr        (clr),
      .start      (start),
      .busy       (busy),
      .done       (done),
      .done_pulse (done_pulse),
      .ld_x       (ld_x),
      .ld_y       (ld_y),
      .shift_y    (shift_y),
      .spm_clr    (spm_clr),
      .prod_clr   (prod_clr),
      .prod_shift (prod_shift),
      .run_cnt    (run_cnt)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Serial signed multiplier: y sign-extends as it shifts, one product bit per step
   always_comb s = acc + (y_r[0] ? {{2{x_r[7]}}, x_r} : 10'sd0);

   always @(posedge clk) begin
      if (ld_x) x_r <= x_in;
      if (ld_y) y_r <= y_in;
      else if (shift_y) y_r <= y_r >>> 1;
      if (spm_clr) acc <= 10'sd0;
      else if (prod_shift) acc <= s >>> 1;
      if (prod_clr) prod <= 16'd0;
      else if (prod_shift) prod <= {s[0], prod[15:1]};
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: every done_pulse must match the oldest outstanding operation
   always @(negedge clk) begin
      if (done_pulse === 1'b1) begin
         if (q.size() == 0) begin
            check("unexpected_done", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = q.pop_front();
            check("product", {16'd0, prod}, {16'd0, e.prod});
            check("done_cycle", cyc, e.cyc);
         end
      end
   end

   task automatic issue(input logic [7:0] x, input logic [7:0] y,
                        input logic [15:0] p, input bit push);
      @(negedge clk);
      x_in  = x;
      y_in  = y;
      start = 1'b1;
      if (push) q.push_back('{prod: p, cyc: cyc + 18});
   endtask

   task automatic full_op(input logic [7:0] x, input logic [7:0] y,
                          input logic [15:0] p, input int mid_start, input bit hold);
      issue(x, y, p, 1'b1);
      @(negedge clk);
      check("load_ctrl", {23'd0, ctrl}, {23'd0, V_LOAD});
      if (!hold) start = 1'b0;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         check("run_ctrl", {23'd0, ctrl}, {23'd0, V_RUN});
         check("run_cnt", {27'd0, run_cnt}, i);
         if (!hold) start = (i == mid_start);
      end
      @(negedge clk);
      check("done1_ctrl", {23'd0, ctrl}, {23'd0, V_DONE1});
      for (int i = 0; i < (hold ? 4 : 1); i++) begin
         @(negedge clk);
         check("done_ctrl", {23'd0, ctrl}, {23'd0, V_DONE});
         check("prod_frozen", {16'd0, prod}, {16'd0, p});
      end
      start = 1'b0;
   endtask

   initial begin
      // Reset with start held high, then release with start still high
      start = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check("reset_ctrl", {23'd0, ctrl}, {23'd0, V_IDLE});
         check("reset_cnt", {27'd0, run_cnt}, 32'd0);
      end
      rst = 1'b0;
      repeat (4) begin
         @(negedge clk);
         check("held_start_idle", {23'd0, ctrl}, {23'd0, V_IDLE});
      end
      start = 1'b0;
      repeat (3) @(negedge clk);

      full_op(8'd13, 8'd11, 16'd143, -1, 1'b0);
      // Back-to-back from DONE, with a start edge at RUN cycle 5 that must be ignored
      full_op(8'hFB, 8'd7, 16'hFFDD, 5, 1'b0);
      // Start level held through DONE must not retrigger
      full_op(8'h7F, 8'h7F, 16'h3F01, -1, 1'b1);

      // Abort at RUN cycle 7 with clr and start together
      issue(8'd1, 8'd1, 16'd0, 1'b0);
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         check("abort_run_cnt", {27'd0, run_cnt}, i);
      end
      clr   = 1'b1;
      start = 1'b1;
      @(negedge clk);
      check("abort_ctrl", {23'd0, ctrl}, {23'd0, V_IDLE});
      check("abort_cnt", {27'd0, run_cnt}, 32'd0);
      clr = 1'b0;
      @(negedge clk);
      check("abort_no_retrigger", {23'd0, ctrl}, {23'd0, V_IDLE});
      start = 1'b0;
      @(negedge clk);
      full_op(8'h55, 8'd3, 16'h00FF, -1, 1'b0);

      full_op(8'd3, 8'hFF, 16'hFFFD, -1, 1'b0);
      full_op(8'h80, 8'h80, 16'h4000, -1, 1'b0);

      repeat (5) @(negedge clk);
      check("queue_drained", q.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
